logic_analyzer_capture_core: RTL

Parametrised next-generation logic-analyzer capture engine: NUM_CH input channels, a single internal circular sample RAM (replaces per-channel FIFOs), programmable pre-trigger depth, four trigger modes, and a framed byte-serial readout to the existing UART transmitter handshake. It sits between the board-level channel pins and the UART TX block. It is configured by the command decoder through the arm pulse plus latched config inputs.

---
 rtl/logic_analyzer_capture_core.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/logic_analyzer_capture_core.sv
// Logic-analyzer capture engine: synchronised channel sampling into a circular
// RAM with pre-trigger history, four trigger modes, and a framed byte-serial
// readout (A5, count hi, count lo, samples oldest first) to a UART handshake.
module logic_analyzer_capture_core #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned DIV_W  = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned NB = (NUM_CH + 7) / 8
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              arm,
    input  logic              abort,
    input  logic [1:0]        trig_mode,
    input  logic [CW-1:0]     trig_ch,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [DIV_W-1:0]  div_cnt,
    input  logic [AW-1:0]     pre_depth,
    input  logic [AW:0]       sample_depth,
    input  logic [NUM_CH-1:0] data_in,
    input  logic              uart_tx_done,
    output logic              uart_send_en,
    output logic [7:0]        uart_tx_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned SW = AW + 1;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned PW = NB * 8;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT_TRIG, S_POST, S_RD_ADDR, S_RD_DATA, S_SEND, S_WAIT_TX
    } state_t;

    state_t state, state_d;

    logic [NUM_CH-1:0] sync1, sync2, prev_smp, en_q, rd_q, smp_q;
    logic              prev_vld;
    logic [1:0]        mode_q, hdr_cnt;
    logic [CW-1:0]     ch_q;
    logic [DIV_W-1:0]  div_q, div_ctr;
    logic [AW-1:0]     p_q, wptr, rd_ptr, pre_cnt;
    logic [SW-1:0]     s_q, post_cnt, smp_cnt;
    logic [BW-1:0]     byte_idx;
    logic [NUM_CH-1:0] mem [DEPTH];

    logic [SW-1:0] s_eff_c, post_need_c;
    logic [AW-1:0] p_eff_c;
    logic          strobe_c, cap_c, wr_c, hit_c, trig_c, arm_ok_c, tx_adv_c, last_byte_c;
    logic          cur_c, prv_c, send_en_c, done_c, busy_c;
    logic [7:0]    tx_byte_c;
    logic [PW-1:0] smp_pad_c;
    logic [15:0]   s16_c;

    // Normalised capture length and clamped pre-trigger depth from the live inputs
    always_comb begin
        s_eff_c = ((sample_depth == '0) || (sample_depth > SW'(DEPTH))) ? SW'(DEPTH) : sample_depth;
        p_eff_c = (SW'(pre_depth) >= s_eff_c) ? AW'(s_eff_c - SW'(1)) : pre_depth;
    end

    // Event decode shared by the FSM and the datapath
    always_comb begin
        post_need_c = s_q - SW'(p_q);
        strobe_c    = (state != S_IDLE) && (div_ctr == div_q);
        cap_c       = (state == S_PRE) || (state == S_WAIT_TRIG) || (state == S_POST);
        wr_c        = strobe_c && cap_c;
        cur_c       = sync2[ch_q];
        prv_c       = prev_smp[ch_q];
        case (mode_q)
            2'b00:   hit_c = prev_vld && !prv_c && cur_c;
            2'b01:   hit_c = prev_vld && prv_c && !cur_c;
            2'b10:   hit_c = cur_c;
            default: hit_c = !cur_c;
        endcase
        trig_c      = (state == S_WAIT_TRIG) && strobe_c && hit_c;
        arm_ok_c    = (state == S_IDLE) && arm && !abort;
        tx_adv_c    = (state == S_WAIT_TX) && uart_tx_done;
        last_byte_c = (hdr_cnt == 2'd3) && (byte_idx == BW'(NB - 1)) && (smp_cnt == s_q - SW'(1));
    end

    // State register
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) state <= S_IDLE;
        else         state <= state_d;
    end

    // Next-state logic; abort overrides every other event
    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (arm) state_d = (p_eff_c == '0) ? S_WAIT_TRIG : S_PRE;
                S_PRE:       if (strobe_c && (pre_cnt == p_q - AW'(1))) state_d = S_WAIT_TRIG;
                S_WAIT_TRIG: if (trig_c) state_d = (post_need_c == SW'(1)) ? S_RD_ADDR : S_POST;
                S_POST:      if (strobe_c && (post_cnt == post_need_c - SW'(1))) state_d = S_RD_ADDR;
                S_RD_ADDR:   state_d = S_RD_DATA;
                S_RD_DATA:   state_d = S_SEND;
                S_SEND:      state_d = S_WAIT_TX;
                S_WAIT_TX: begin
                    if (uart_tx_done) begin
                        if (last_byte_c)                                        state_d = S_IDLE;
                        else if ((hdr_cnt != 2'd3) || (byte_idx != BW'(NB - 1))) state_d = S_SEND;
                        else                                                    state_d = S_RD_ADDR;
                    end
                end
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Output decode: byte mux and next values of the registered outputs
    always_comb begin
        smp_pad_c = PW'(smp_q);
        s16_c     = 16'(s_q);
        case (hdr_cnt)
            2'd0:    tx_byte_c = 8'hA5;
            2'd1:    tx_byte_c = s16_c[15:8];
            2'd2:    tx_byte_c = s16_c[7:0];
            default: tx_byte_c = smp_pad_c[{byte_idx, 3'b000} +: 8];
        endcase
        send_en_c = (state == S_SEND) && !abort;
        done_c    = tx_adv_c && last_byte_c && !abort;
        busy_c    = (state_d != S_IDLE);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            uart_send_en <= 1'b0;
            uart_tx_data <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            uart_send_en <= send_en_c;
            if (send_en_c) uart_tx_data <= tx_byte_c;
            busy         <= busy_c;
            done         <= done_c;
        end
    end

    // Input synchroniser, config latch, divider, pointers and readout sequencing
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync1    <= '0;
            sync2    <= '0;
            prev_smp <= '0;
            prev_vld <= 1'b0;
            mode_q   <= '0;
            ch_q     <= '0;
            en_q     <= '0;
            div_q    <= '0;
            p_q      <= '0;
            s_q      <= '0;
            div_ctr  <= '0;
            wptr     <= '0;
            rd_ptr   <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            smp_cnt  <= '0;
            hdr_cnt  <= '0;
            byte_idx <= '0;
            smp_q    <= '0;
        end else begin
            sync1 <= data_in;
            sync2 <= sync1;
            if (arm_ok_c) begin
                mode_q   <= trig_mode;
                ch_q     <= (32'(trig_ch) >= NUM_CH) ? '0 : trig_ch;
                en_q     <= ch_en;
                div_q    <= div_cnt;
                p_q      <= p_eff_c;
                s_q      <= s_eff_c;
                wptr     <= '0;
                pre_cnt  <= '0;
                post_cnt <= '0;
                prev_vld <= 1'b0;
                smp_cnt  <= '0;
                hdr_cnt  <= '0;
                byte_idx <= '0;
            end
            if ((state == S_IDLE) || strobe_c) div_ctr <= '0;
            else                               div_ctr <= div_ctr + 1'b1;
            if (wr_c) begin
                prev_smp <= sync2;
                prev_vld <= 1'b1;
                wptr     <= wptr + 1'b1;
            end
            if ((state == S_PRE) && strobe_c) pre_cnt <= pre_cnt + 1'b1;
            if (trig_c) begin
                rd_ptr   <= wptr - p_q;
                post_cnt <= SW'(1);
            end
            if ((state == S_POST) && strobe_c) post_cnt <= post_cnt + 1'b1;
            if (state == S_RD_DATA) smp_q <= rd_q & en_q;
            if (tx_adv_c && !last_byte_c) begin
                if (hdr_cnt != 2'd3) begin
                    hdr_cnt <= hdr_cnt + 1'b1;
                end else if (byte_idx != BW'(NB - 1)) begin
                    byte_idx <= byte_idx + 1'b1;
                end else begin
                    byte_idx <= '0;
                    smp_cnt  <= smp_cnt + 1'b1;
                    rd_ptr   <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Sample RAM: write on capture strobes, one-cycle registered read
    always_ff @(posedge clk) begin
        if (wr_c) mem[wptr] <= sync2;
        if (state == S_RD_ADDR) rd_q <= mem[rd_ptr];
    end

endmodule
